i2c_mem_slave: RTL
==================

Name: i2c_mem_slave

Overview:
- I2C target that consumes the serial bus driven by the I2C master interface and fronts a small byte-addressed register memory.
- Decodes START/STOP, matches a 7-bit device address, and takes a one-byte register pointer.
- Then either writes incoming data bytes into memory or returns memory bytes to the master, with auto-increment.
- It is the slave stage the memory subsystem attaches to the master's SCL/SDA.

Parameters:
- SLAVE_ADDR, 7'h50, device address matched against the first byte after START.
- DEPTH, 16, number of bytes in the memory; must be a power of two and ≤256.
- AW, $clog2(DEPTH), width of the internal pointer.

Ports:
- clk  in  1  system clock; must be ≥8× the SCL rate.
- rst  in  1  asynchronous active-low reset.
- scl  in  1  bus clock from the master, raw and asynchronous.
- sda_in  in  1  bus data as seen on the wire, raw and asynchronous.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- busy  out  1  high from an address-matched START until STOP or NACK-return-to-idle.
- wr_pulse  out  1  one-clk strobe when a data byte is committed to memory.
- wr_addr  out  AW  memory index of the last committed byte.
- wr_data  out  8  value of the last committed byte.
- rd_pulse  out  1  one-clk strobe when a byte is loaded for transmission.

Behaviour:
- Reset (rst=0, async):
  - sda_oe=0, busy=0, wr_pulse=0, rd_pulse=0, wr_addr=0, wr_data=0.
  - Pointer=0, FSM=IDLE, synchronizers preset to 1.
  - Memory contents reset to 0.
- Input conditioning:
  - scl and sda_in each pass through a 2-flop synchronizer, then one history flop.
  - Edge/condition detection therefore lags the wire by 3 clk.
- Bus conditions:
  - START: synced SDA falls while synced SCL is high.
  - STOP: synced SDA rises while synced SCL is high.
  - Sampling happens on SCL rising edges; sda_oe changes only on SCL falling edges.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits MSB-first.
    - On a match with SLAVE_ADDR, go to DEV_ACK and assert busy.
    - On a mismatch, go to IDLE with sda_oe held 0.
  - DEV_ACK:
    - sda_oe=1 from the falling edge after bit 8 until the next falling edge.
    - Then go to PTR if R/W=0. If R/W=1, go to RD_DATA, which loads mem[pointer] and pulses rd_pulse.
  - PTR: shift 8 bits; pointer = byte[AW-1:0] (upper bits ignored); then PTR_ACK, which acks and goes to WR_DATA.
  - WR_DATA: shift 8 bits, then WR_ACK.
    - Commit on the 8th rising edge: mem[pointer]=byte, wr_pulse for 1 clk, wr_addr=pointer, wr_data=byte, pointer+1.
    - WR_ACK acks and returns to WR_DATA.
  - RD_DATA: drive sda_oe=~bit[7-k] on each falling edge; after 8 bits, release and go to RD_ACK.
    - Pointer increments when the byte is loaded.
  - RD_ACK: sample SDA on the rising edge.
    - 0 (ACK): go to RD_DATA, load the next byte, pulse rd_pulse.
    - 1 (NACK): go to IDLE and release the bus.
- Pointer wraps modulo DEPTH: DEPTH-1 is followed by 0.
- Repeated START in any state: go to DEV_ADDR, clear the bit counter, keep the pointer. This supports write-pointer-then-read.
- STOP in any state: go to IDLE, sda_oe=0, busy=0. A partial byte is discarded and not committed.
- START and STOP are evaluated before data sampling when detected on the same clk.
- Master-write overrun cannot occur: each byte is committed within 1 clk.

Decomposition:
- Package i2c_pkg holds:
  - the i2c_state_e enum (nine states above);
  - localparams ACK=1'b0 and NACK=1'b1;
  - the bit-count width of 3.
- One natural sub-module: i2c_bus_sync. It contains the synchronizers plus detection of scl_rise, scl_fall, start_det and stop_det, each as a 1-clk pulse.

Test Plan:
- Write single byte: START, 0xA0 (0x50+W), ptr 0x0A, data 0x64, STOP → ACK on all 3 bytes; wr_pulse once with wr_addr=0xA, wr_data=0x64; busy drops after STOP.
- Random read: ptr 0x0A, repeated START, 0xA1, read 1 byte with NACK → SDA shows 0x64 MSB-first; rd_pulse once; FSM returns to IDLE, sda_oe=0.
- Wrap on burst write: ptr 0x0F, data 0x11, 0x22, 0x33 → mem[15]=0x11, mem[0]=0x22, mem[1]=0x33; wr_addr sequence 15, 0, 1.
- Address mismatch: START, 0xA2 (0x51), then data → sda_oe stays 0 throughout; no wr_pulse; busy stays 0.
- STOP mid-byte: after ptr 0x03, send 4 data bits then STOP → no commit; mem[3] unchanged; IDLE.
- Async reset mid-read: assert rst=0 during RD_DATA bit 3 → sda_oe=0 immediately; all outputs at reset values; the next full transaction works.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C memory target: FSM states, ACK/NACK
// bus levels and the bit-counter width.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } i2c_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int BCW = 3;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings raw SCL/SDA into the clk domain (2-flop sync + history flop) and
// produces single-clk pulses for SCL edges and START/STOP conditions.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_hist, sda_hist;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
    end
  end

  assign sda_s     = sda_sync[1];
  assign scl_rise  =  scl_sync[1] & ~scl_hist;
  assign scl_fall  = ~scl_sync[1] &  scl_hist;
  // SDA may only move while SCL is high when the master signals a condition
  assign start_det =  scl_sync[1] & scl_hist &  sda_hist & ~sda_sync[1];
  assign stop_det  =  scl_sync[1] & scl_hist & ~sda_hist &  sda_sync[1];

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C target fronting a small byte memory: device-address match, one-byte
// register pointer, then auto-incrementing writes or reads.
module i2c_mem_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16,
  parameter int         AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_pulse,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          rd_pulse
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_e     state, state_d;
  logic [BCW-1:0] bit_cnt, bit_cnt_d;
  logic [6:0]     shift_q, shift_d;
  logic [7:0]     tx_q, tx_d;
  logic [AW-1:0]  ptr, ptr_d, wr_addr_d;
  logic [7:0]     wr_data_d;
  logic           rw_q, rw_d, sda_oe_d, busy_d, wr_pulse_d, rd_pulse_d, mem_we;
  logic [7:0]     mem [DEPTH];

  // Byte as it stands once the current rising-edge bit is shifted in
  wire logic [7:0] rx_byte = {shift_q, sda_s};
  wire logic [7:0] rd_byte = mem[ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift_q  <= '0;
      tx_q     <= '0;
      ptr      <= '0;
      rw_q     <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
      rd_pulse <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ptr      <= ptr_d;
      rw_q     <= rw_d;
      sda_oe   <= sda_oe_d;
      busy     <= busy_d;
      wr_pulse <= wr_pulse_d;
      rd_pulse <= rd_pulse_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
    end
  end

  // NOTE: the register file is cleared by reset, so a read before any write
  // returns 0; this costs a reset on every memory flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[ptr] <= rx_byte;
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe;
    busy_d     = busy;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    wr_pulse_d = 1'b0;
    rd_pulse_d = 1'b0;
    mem_we     = 1'b0;

    if (start_det) begin
      state_d   = DEV_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state)
        DEV_ADDR, PTR, WR_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt + 1'b1;
            if (bit_cnt == '1) begin
              if (state == DEV_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = DEV_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = IDLE;
                end
              end else if (state == PTR) begin
                ptr_d   = rx_byte[AW-1:0];
                state_d = PTR_ACK;
              end else begin
                mem_we     = 1'b1;
                wr_pulse_d = 1'b1;
                wr_addr_d  = ptr;
                wr_data_d  = rx_byte;
                ptr_d      = ptr + 1'b1;
                state_d    = WR_ACK;
              end
            end
          end
        end
        DEV_ACK, PTR_ACK, WR_ACK: begin
          // First falling edge pulls SDA for the ACK, the second ends it
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state == DEV_ACK && rw_q) begin
                tx_d       = rd_byte;
                sda_oe_d   = ~rd_byte[7];
                rd_pulse_d = 1'b1;
                ptr_d      = ptr + 1'b1;
                state_d    = RD_DATA;
              end else if (state == DEV_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt + 1'b1;
            if (bit_cnt == '1) state_d = RD_ACK;
          end else if (scl_fall) begin
            sda_oe_d = ~tx_q[3'd7 - bit_cnt];
          end
        end
        RD_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (sda_s == ACK) begin
              tx_d       = rd_byte;
              rd_pulse_d = 1'b1;
              ptr_d      = ptr + 1'b1;
              bit_cnt_d  = '0;
              state_d    = RD_DATA;
            end else begin
              state_d  = IDLE;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
